// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Purpose  : Shared types and constants for the uart_trx block: parity
//            encoding, TX/RX state encodings, minimum bit-period divisor and
//            small helpers for data-width handling.
// Ports    : none (package)
// Revision : 1.0  initial release
// ============================================================================
package uart_pkg;

    // Parity selection as presented on cfg_parity_i (11 behaves as none)
    typedef enum logic [1:0] {
        PAR_NONE     = 2'b00,
        PAR_EVEN     = 2'b01,
        PAR_ODD      = 2'b10,
        PAR_NONE_ALT = 2'b11
    } parity_e;

    typedef enum logic [2:0] {
        TX_IDLE   = 3'd0,
        TX_START  = 3'd1,
        TX_DATA   = 3'd2,
        TX_PARITY = 3'd3,
        TX_STOP   = 3'd4
    } tx_state_e;

    typedef enum logic [2:0] {
        RX_IDLE   = 3'd0,
        RX_START  = 3'd1,
        RX_DATA   = 3'd2,
        RX_PARITY = 3'd3,
        RX_STOP   = 3'd4
    } rx_state_e;

    // Smallest usable bit period; anything shorter is stretched to this
    localparam int unsigned c_MIN_DIV = 4;

    // Mask selecting the active data bits for a cfg_bits code (00=5 .. 11=8)
    function automatic logic [7:0] data_mask(input logic [1:0] bits);
        return 8'hFF >> (2'd3 - bits);
    endfunction

    // Number of data bits for a cfg_bits code
    function automatic logic [3:0] num_bits(input logic [1:0] bits);
        return {2'b00, bits} + 4'd5;
    endfunction

    function automatic logic parity_enabled(input parity_e par);
        return (par == PAR_EVEN) || (par == PAR_ODD);
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_fifo
// Purpose  : Synchronous FIFO for received characters. Show-ahead head
//            output; a pop and a push in the same cycle on a full FIFO are
//            both accepted (the pop frees the slot the push fills).
// Ports    : clk, rst_n           clock, async active-low reset
//            i_push, i_data        write request and data
//            i_pop                 read request (ignored when empty)
//            o_data                head entry
//            o_empty, o_full       status
//            o_level               occupancy 0..DEPTH
// Revision : 1.0  initial release
// ============================================================================
module uart_fifo #(
    parameter int DATA_W = 9,
    parameter int DEPTH  = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_push,
    input  logic [DATA_W-1:0]          i_data,
    input  logic                       i_pop,
    output logic [DATA_W-1:0]          o_data,
    output logic                       o_empty,
    output logic                       o_full,
    output logic [$clog2(DEPTH):0]     o_level
);
    localparam int c_AW = $clog2(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]   r_wr_ptr;
    logic [c_AW-1:0]   r_rd_ptr;
    logic [c_AW:0]     r_count;
    logic              w_do_pop;
    logic              w_do_push;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == (c_AW+1)'(DEPTH));
    assign o_level   = r_count;
    assign o_data    = r_mem[r_rd_ptr];
    assign w_do_pop  = i_pop & ~o_empty;
    // Pop is resolved first, so a full FIFO still takes a simultaneous push
    assign w_do_push = i_push & (~o_full | w_do_pop);

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + c_AW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + c_AW'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (c_AW+1)'(1);
                2'b01:   r_count <= r_count - (c_AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_data;
    end

endmodule
`default_nettype wire

// File: rtl/uart_trx.sv
`default_nettype none
// ============================================================================
// Module   : uart_trx
// Purpose  : Full-duplex UART with run-time frame configuration (5..8 data
//            bits, none/even/odd parity, 1/2 TX stop bits), a valid/ready
//            TX byte interface and an RX FIFO carrying {perr, data}.
// Ports    : clk, rst_n                    clock, async active-low reset
//            cfg_div_i/bits/parity/stop2   frame configuration
//            tx_data_i/valid_i/ready_o     TX byte handshake
//            rx_data/perr/valid_o,ready_i  RX FIFO head handshake
//            tx_o, rx_i                    serial lines
//            ferr_o, ovf_o, err_clr_i      sticky error flags and clear
//            rx_level_o                    RX FIFO occupancy
// Revision : 1.0  initial release
// ============================================================================
module uart_trx
    import uart_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int DIV_W      = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [DIV_W-1:0]              cfg_div_i,
    input  logic [1:0]                    cfg_bits_i,
    input  logic [1:0]                    cfg_parity_i,
    input  logic                          cfg_stop2_i,
    input  logic [7:0]                    tx_data_i,
    input  logic                          tx_valid_i,
    output logic                          tx_ready_o,
    output logic [7:0]                    rx_data_o,
    output logic                          rx_perr_o,
    output logic                          rx_valid_o,
    input  logic                          rx_ready_i,
    output logic                          tx_o,
    input  logic                          rx_i,
    output logic                          ferr_o,
    output logic                          ovf_o,
    input  logic                          err_clr_i,
    output logic [$clog2(FIFO_DEPTH):0]   rx_level_o
);
    logic [DIV_W-1:0] w_div_clamped;
    assign w_div_clamped = (cfg_div_i < DIV_W'(c_MIN_DIV)) ? DIV_W'(c_MIN_DIV) : cfg_div_i;

    // ------------------------------------------------------------------ TX
    tx_state_e        r_tx_state, w_tx_next;
    logic [DIV_W-1:0] r_tx_cnt, r_tx_div;
    logic [3:0]       r_tx_nbits;
    logic [2:0]       r_tx_idx;
    parity_e          r_tx_par;
    logic             r_tx_stop2, r_tx_second, r_tx_pbit;
    logic [7:0]       r_tx_shift;
    logic             w_tx_bit_end, w_tx_last, w_tx_line;

    assign w_tx_bit_end = (r_tx_cnt == r_tx_div - DIV_W'(1));
    assign w_tx_last    = ({1'b0, r_tx_idx} == r_tx_nbits - 4'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_tx_state <= TX_IDLE;
        else        r_tx_state <= w_tx_next;
    end

    always_comb begin
        w_tx_next = r_tx_state;
        w_tx_line = 1'b1;
        case (r_tx_state)
            TX_IDLE:   if (tx_valid_i) w_tx_next = TX_START;
            TX_START: begin
                w_tx_line = 1'b0;
                if (w_tx_bit_end) w_tx_next = TX_DATA;
            end
            TX_DATA: begin
                w_tx_line = r_tx_shift[0];
                if (w_tx_bit_end && w_tx_last)
                    w_tx_next = parity_enabled(r_tx_par) ? TX_PARITY : TX_STOP;
            end
            TX_PARITY: begin
                w_tx_line = r_tx_pbit;
                if (w_tx_bit_end) w_tx_next = TX_STOP;
            end
            TX_STOP:   if (w_tx_bit_end && (!r_tx_stop2 || r_tx_second)) w_tx_next = TX_IDLE;
            default:   w_tx_next = TX_IDLE;
        endcase
    end

    // Frame configuration is captured on acceptance and held for the frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx_cnt    <= '0;
            r_tx_div    <= DIV_W'(c_MIN_DIV);
            r_tx_nbits  <= 4'd8;
            r_tx_idx    <= '0;
            r_tx_par    <= PAR_NONE;
            r_tx_stop2  <= 1'b0;
            r_tx_second <= 1'b0;
            r_tx_pbit   <= 1'b0;
            r_tx_shift  <= '0;
        end else if (r_tx_state == TX_IDLE) begin
            r_tx_cnt    <= '0;
            r_tx_idx    <= '0;
            r_tx_second <= 1'b0;
            if (tx_valid_i) begin
                r_tx_div   <= w_div_clamped;
                r_tx_nbits <= num_bits(cfg_bits_i);
                r_tx_par   <= parity_e'(cfg_parity_i);
                r_tx_stop2 <= cfg_stop2_i;
                r_tx_shift <= tx_data_i;
                r_tx_pbit  <= (^(tx_data_i & data_mask(cfg_bits_i)))
                              ^ (parity_e'(cfg_parity_i) == PAR_ODD);
            end
        end else if (w_tx_bit_end) begin
            r_tx_cnt <= '0;
            if (r_tx_state == TX_DATA) begin
                r_tx_shift <= r_tx_shift >> 1;
                r_tx_idx   <= r_tx_idx + 3'd1;
            end
            if (r_tx_state == TX_STOP) r_tx_second <= 1'b1;
        end else begin
            r_tx_cnt <= r_tx_cnt + DIV_W'(1);
        end
    end

    // Both outputs follow the async reset immediately (no clock needed)
    assign tx_o       = w_tx_line;
    assign tx_ready_o = (r_tx_state == TX_IDLE) && rst_n;

    // ------------------------------------------------------------------ RX
    rx_state_e        r_rx_state, w_rx_next;
    logic             r_rx_s1, r_rx_s2, r_rx_s3;
    logic [DIV_W-1:0] r_rx_cnt, r_rx_div, w_rx_target;
    logic [3:0]       r_rx_nbits;
    logic [2:0]       r_rx_idx;
    parity_e          r_rx_par;
    logic [7:0]       r_rx_data;
    logic             r_rx_pacc, r_rx_perr;
    logic             w_rx_fall, w_rx_hit, w_rx_last;
    logic             w_push, w_pop, w_ferr_set, w_ovf_set, w_full, w_empty;
    logic [8:0]       w_head;

    // s1/s2 form the synchronizer; s3 only delays s2 for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_s1 <= 1'b1;
            r_rx_s2 <= 1'b1;
            r_rx_s3 <= 1'b1;
        end else begin
            r_rx_s1 <= rx_i;
            r_rx_s2 <= r_rx_s1;
            r_rx_s3 <= r_rx_s2;
        end
    end

    // A falling edge needs the line high first, which also re-arms after a
    // framing error only once the line has returned high.
    assign w_rx_fall   = r_rx_s3 & ~r_rx_s2;
    assign w_rx_target = (r_rx_state == RX_START) ? (r_rx_div >> 1) : r_rx_div;
    assign w_rx_hit    = (r_rx_cnt == w_rx_target);
    assign w_rx_last   = ({1'b0, r_rx_idx} == r_rx_nbits - 4'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_rx_state <= RX_IDLE;
        else        r_rx_state <= w_rx_next;
    end

    always_comb begin
        w_rx_next  = r_rx_state;
        w_push     = 1'b0;
        w_ferr_set = 1'b0;
        case (r_rx_state)
            RX_IDLE:   if (w_rx_fall) w_rx_next = RX_START;
            RX_START:  if (w_rx_hit) w_rx_next = r_rx_s2 ? RX_IDLE : RX_DATA;
            RX_DATA:   if (w_rx_hit && w_rx_last)
                           w_rx_next = parity_enabled(r_rx_par) ? RX_PARITY : RX_STOP;
            RX_PARITY: if (w_rx_hit) w_rx_next = RX_STOP;
            RX_STOP: begin
                if (w_rx_hit) begin
                    w_rx_next  = RX_IDLE;
                    w_push     = r_rx_s2;
                    w_ferr_set = ~r_rx_s2;
                end
            end
            default:   w_rx_next = RX_IDLE;
        endcase
    end

    // Counter restarts at 1 so a match on N means N cycles since the
    // previous reference point (start edge or previous sample).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_cnt   <= DIV_W'(1);
            r_rx_div   <= DIV_W'(c_MIN_DIV);
            r_rx_nbits <= 4'd8;
            r_rx_idx   <= '0;
            r_rx_par   <= PAR_NONE;
            r_rx_data  <= '0;
            r_rx_pacc  <= 1'b0;
            r_rx_perr  <= 1'b0;
        end else if (r_rx_state == RX_IDLE) begin
            r_rx_cnt <= DIV_W'(1);
            r_rx_idx <= '0;
            if (w_rx_fall) begin
                r_rx_div   <= w_div_clamped;
                r_rx_nbits <= num_bits(cfg_bits_i);
                r_rx_par   <= parity_e'(cfg_parity_i);
                r_rx_data  <= '0;
                r_rx_pacc  <= 1'b0;
                r_rx_perr  <= 1'b0;
            end
        end else if (w_rx_hit) begin
            r_rx_cnt <= DIV_W'(1);
            if (r_rx_state == RX_DATA) begin
                r_rx_data[r_rx_idx] <= r_rx_s2;
                r_rx_pacc           <= r_rx_pacc ^ r_rx_s2;
                r_rx_idx            <= r_rx_idx + 3'd1;
            end
            if (r_rx_state == RX_PARITY)
                r_rx_perr <= r_rx_pacc ^ r_rx_s2 ^ (r_rx_par == PAR_ODD);
        end else begin
            r_rx_cnt <= r_rx_cnt + DIV_W'(1);
        end
    end

    // ---------------------------------------------------------------- FIFO
    assign w_pop     = ~w_empty & rx_ready_i;
    assign w_ovf_set = w_push & w_full & ~w_pop;

    uart_fifo #(
        .DATA_W (9),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_data  ({r_rx_perr, r_rx_data}),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_empty (w_empty),
        .o_full  (w_full),
        .o_level (rx_level_o)
    );

    assign rx_valid_o = ~w_empty;
    assign rx_data_o  = w_head[7:0];
    assign rx_perr_o  = w_head[8];

    // Sticky flags: a set event wins over a same-cycle clear
    logic r_ferr, r_ovf;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ferr <= 1'b0;
            r_ovf  <= 1'b0;
        end else begin
            if (w_ferr_set)     r_ferr <= 1'b1;
            else if (err_clr_i) r_ferr <= 1'b0;
            if (w_ovf_set)      r_ovf  <= 1'b1;
            else if (err_clr_i) r_ovf  <= 1'b0;
        end
    end
    assign ferr_o = r_ferr;
    assign ovf_o  = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_uart_trx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_uart_trx
// Purpose  : Directed self-checking bench for uart_trx. Received characters
//            are predicted into a scoreboard queue when a frame is driven and
//            compared when they appear at the RX FIFO head.
// Revision : 1.0  initial release
// ============================================================================
module tb_uart_trx;
    localparam int FIFO_DEPTH = 8;
    localparam int DIV_W      = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [DIV_W-1:0] cfg_div;
    logic [1:0]       cfg_bits, cfg_parity;
    logic             cfg_stop2;
    logic [7:0]       tx_data;
    logic             tx_valid, tx_ready;
    logic [7:0]       rx_data;
    logic             rx_perr, rx_valid, rx_ready;
    logic             tx_line, rx_drv, loop_en;
    wire              rx_line;
    logic             ferr, ovf, err_clr;
    logic [$clog2(FIFO_DEPTH):0] rx_level;

    logic [8:0] sb_q[$];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign rx_line = loop_en ? tx_line : rx_drv;

    uart_trx #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .DIV_W      (DIV_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cfg_div_i    (cfg_div),
        .cfg_bits_i   (cfg_bits),
        .cfg_parity_i (cfg_parity),
        .cfg_stop2_i  (cfg_stop2),
        .tx_data_i    (tx_data),
        .tx_valid_i   (tx_valid),
        .tx_ready_o   (tx_ready),
        .rx_data_o    (rx_data),
        .rx_perr_o    (rx_perr),
        .rx_valid_o   (rx_valid),
        .rx_ready_i   (rx_ready),
        .tx_o         (tx_line),
        .rx_i         (rx_line),
        .ferr_o       (ferr),
        .ovf_o        (ovf),
        .err_clr_i    (err_clr),
        .rx_level_o   (rx_level)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_bit(input logic b, input int div);
        rx_drv = b;
        repeat (div) @(negedge clk);
    endtask

    // par: 0 none, 1 even, 2 odd; flip corrupts the parity bit
    task automatic drive_frame(input logic [7:0] d, input int nb, input int par,
                               input logic flip, input logic stop_v, input int div);
        logic p;
        p = 1'b0;
        for (int i = 0; i < nb; i++) p ^= d[i];
        if (par == 2) p = ~p;
        if (flip)     p = ~p;
        drive_bit(1'b0, div);
        for (int i = 0; i < nb; i++) drive_bit(d[i], div);
        if (par != 0) drive_bit(p, div);
        drive_bit(stop_v, div);
        drive_bit(1'b1, div);
    endtask

    task automatic read_entry(input string tag);
        logic [8:0] exp;
        int n;
        n = 0;
        while (!rx_valid && n < 4000) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_valid"}, 32'(rx_valid), 32'd1);
        if (rx_valid) begin
            check({tag, "_sb_nonempty"}, 32'(sb_q.size() != 0), 32'd1);
            if (sb_q.size() != 0) begin
                exp = sb_q.pop_front();
                check({tag, "_data"}, 32'(rx_data), 32'(exp[7:0]));
                check({tag, "_perr"}, 32'(rx_perr), 32'(exp[8]));
            end
            rx_ready = 1'b1;
            @(negedge clk);
            rx_ready = 1'b0;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] frame;
        logic       seen;
        int         n;
        logic [7:0] d;

        rst_n = 1'b0; rx_drv = 1'b1; loop_en = 1'b0;
        tx_valid = 1'b0; tx_data = '0; rx_ready = 1'b0; err_clr = 1'b0;
        cfg_div = 16'd16; cfg_bits = 2'b11; cfg_parity = 2'b00; cfg_stop2 = 1'b0;

        // ---- reset state
        repeat (3) @(negedge clk);
        check("rst_tx_o",     32'(tx_line),  32'd1);
        check("rst_tx_ready", 32'(tx_ready), 32'd0);
        check("rst_rx_valid", 32'(rx_valid), 32'd0);
        check("rst_level",    32'(rx_level), 32'd0);
        check("rst_ferr",     32'(ferr),     32'd0);
        check("rst_ovf",      32'(ovf),      32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("tx_ready_after_rst", 32'(tx_ready), 32'd1);

        // ---- TX 0xA5, 8N1, div 16
        frame = {1'b1, 8'hA5, 1'b0};
        tx_data = 8'hA5; tx_valid = 1'b1;
        @(posedge clk);
        for (int b = 0; b < 10; b++) begin
            seen = frame[b];
            for (int c = 0; c < 16; c++) begin
                @(negedge clk);
                tx_valid = 1'b0;
                if (tx_line !== frame[b]) seen = tx_line;
            end
            check($sformatf("tx_a5_bit%0d", b), 32'(seen), 32'(frame[b]));
        end
        check("tx_ready_159", 32'(tx_ready), 32'd0);
        @(negedge clk);
        check("tx_ready_160", 32'(tx_ready), 32'd1);
        check("tx_a5_no_rx", 32'(rx_level), 32'd0);

        // ---- loopback 0x55, 7E2, div 10 (0x55 has four ones -> parity 0)
        cfg_div = 16'd10; cfg_bits = 2'b10; cfg_parity = 2'b01; cfg_stop2 = 1'b1;
        loop_en = 1'b1;
        sb_q.push_back({1'b0, 8'h55});
        tx_data = 8'h55; tx_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        tx_valid = 1'b0;
        n = 0;
        while (!tx_ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("loop_frame_len", 32'(n), 32'd110);
        read_entry("loop_55");
        check("loop_ferr", 32'(ferr), 32'd0);
        loop_en = 1'b0;

        // ---- 8O1, 0x3C with wrong parity
        cfg_div = 16'd16; cfg_bits = 2'b11; cfg_parity = 2'b10; cfg_stop2 = 1'b0;
        sb_q.push_back({1'b1, 8'h3C});
        drive_frame(8'h3C, 8, 2, 1'b1, 1'b1, 16);
        read_entry("perr_3c");
        check("perr_3c_ferr", 32'(ferr), 32'd0);

        // ---- 8E1, 0xC1 with correct parity
        cfg_parity = 2'b01;
        sb_q.push_back({1'b0, 8'hC1});
        drive_frame(8'hC1, 8, 1, 1'b0, 1'b1, 16);
        read_entry("par_ok_c1");

        // ---- 5N1, only the low five bits of 0xF3 travel
        cfg_bits = 2'b00; cfg_parity = 2'b00;
        sb_q.push_back({1'b0, 8'h13});
        drive_frame(8'hF3, 5, 0, 1'b0, 1'b1, 16);
        read_entry("five_bit");

        // ---- framing error, then clear
        cfg_bits = 2'b11;
        drive_frame(8'h5A, 8, 0, 1'b0, 1'b0, 16);
        check("ferr_set",   32'(ferr),     32'd1);
        check("ferr_level", 32'(rx_level), 32'd0);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        check("ferr_clr", 32'(ferr), 32'd0);

        // ---- overflow: 9 frames into a depth-8 FIFO, div 8
        cfg_div = 16'd8;
        for (int i = 0; i < 9; i++) begin
            d = 8'(i * 29 + 7);
            if (i < FIFO_DEPTH) sb_q.push_back({1'b0, d});
            drive_frame(d, 8, 0, 1'b0, 1'b1, 8);
        end
        check("ovf_level", 32'(rx_level), 32'd8);
        check("ovf_flag",  32'(ovf),      32'd1);
        for (int i = 0; i < FIFO_DEPTH; i++) read_entry($sformatf("ovf_rd%0d", i));
        check("ovf_drained", 32'(rx_level), 32'd0);
        check("ovf_sb_empty", 32'(sb_q.size()), 32'd0);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        check("ovf_clr", 32'(ovf), 32'd0);

        // ---- 3-cycle glitch, div 16
        cfg_div = 16'd16;
        rx_drv = 1'b0;
        repeat (3) @(negedge clk);
        rx_drv = 1'b1;
        repeat (40) @(negedge clk);
        check("glitch_level", 32'(rx_level), 32'd0);
        check("glitch_ferr",  32'(ferr),     32'd0);

        // ---- reset in the middle of a TX frame (0x00 -> line low in data)
        tx_data = 8'h00; tx_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        tx_valid = 1'b0;
        repeat (20) @(negedge clk);
        check("midtx_line_low", 32'(tx_line), 32'd0);
        rst_n = 1'b0;
        #1;
        check("midtx_rst_tx_o",     32'(tx_line),  32'd1);
        check("midtx_rst_tx_ready", 32'(tx_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("midtx_ready_after", 32'(tx_ready), 32'd1);
        check("midtx_level",       32'(rx_level), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
